// File: rtl/wb_cache.sv
// Direct-mapped write-back, write-allocate cache with an explicit flush sweep.
// The processor side talks in words; the memory side moves whole lines.
module wb_cache #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int INDEX_W  = 3,
   parameter int OFFSET_W = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             PRead_request,
   input  logic                             PWrite_request,
   input  logic [ADDR_W-1:0]                PAddress,
   input  logic [DATA_W-1:0]                PWrite_data,
   output logic [DATA_W-1:0]                PRead_data,
   output logic                             PRead_ready,
   output logic                             PWrite_done,
   input  logic                             Flush_request,
   output logic                             Flush_done,
   output logic                             MRead_request,
   output logic                             MWrite_request,
   output logic [ADDR_W-1:0]                MAddress,
   output logic [DATA_W*(2**OFFSET_W)-1:0]  MWrite_data,
   input  logic [DATA_W*(2**OFFSET_W)-1:0]  MRead_data,
   input  logic                             MRead_ready,
   input  logic                             MWrite_done
);

   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES  = 2 ** INDEX_W;
   localparam int WORDS  = 2 ** OFFSET_W;
   localparam int LINE_W = DATA_W * WORDS;

   typedef enum logic [3:0] {
      S_IDLE, S_TEST, S_EVICT, S_FILL, S_ALLOC,
      S_R_READY, S_W_DONE, S_F_SCAN, S_F_WB, S_F_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                is_write_q, is_write_d;
   logic                wr_block_q, wr_block_d;
   logic [INDEX_W-1:0]  fidx_q, fidx_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINES-1:0]    dirty_q, dirty_d;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [TAG_W-1:0]    tag_d  [LINES];
   logic [LINE_W-1:0]   data_q [LINES];
   logic [LINE_W-1:0]   data_d [LINES];

   logic [INDEX_W-1:0]  cur_idx;
   logic [TAG_W-1:0]    cur_tag;
   logic [OFFSET_W-1:0] cur_off;
   logic                hit;
   logic                do_access;

   function automatic logic [DATA_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_W-1:0] off);
      logic [DATA_W-1:0] val;
      val = '0;
      for (int w = 0; w < WORDS; w++)
         if (off == w[OFFSET_W-1:0]) val = line[w*DATA_W +: DATA_W];
      return val;
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_W-1:0] off,
                                                  input logic [DATA_W-1:0] val);
      logic [LINE_W-1:0] res;
      res = line;
      for (int w = 0; w < WORDS; w++)
         if (off == w[OFFSET_W-1:0]) res[w*DATA_W +: DATA_W] = val;
      return res;
   endfunction

   assign cur_off    = addr_q[OFFSET_W-1:0];
   assign cur_idx    = addr_q[OFFSET_W +: INDEX_W];
   assign cur_tag    = addr_q[ADDR_W-1 -: TAG_W];
   assign hit        = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
   assign PRead_data = rdata_q;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      is_write_d     = is_write_q;
      rdata_d        = rdata_q;
      fidx_d         = fidx_q;
      // a write seen together with a read must be dropped before it counts again
      wr_block_d     = wr_block_q & PWrite_request;
      valid_d        = valid_q;
      dirty_d        = dirty_q;
      tag_d          = tag_q;
      data_d         = data_q;
      do_access      = 1'b0;
      PRead_ready    = 1'b0;
      PWrite_done    = 1'b0;
      Flush_done     = 1'b0;
      MRead_request  = 1'b0;
      MWrite_request = 1'b0;
      MAddress       = '0;
      MWrite_data    = '0;
      case (state_q)
         S_IDLE: begin
            if (PRead_request) begin
               addr_d     = PAddress;
               wdata_d    = PWrite_data;
               is_write_d = 1'b0;
               wr_block_d = PWrite_request;
               state_d    = S_TEST;
            end else if (PWrite_request && !wr_block_q) begin
               addr_d     = PAddress;
               wdata_d    = PWrite_data;
               is_write_d = 1'b1;
               state_d    = S_TEST;
            end else if (Flush_request) begin
               fidx_d  = '0;
               state_d = S_F_SCAN;
            end
         end
         S_TEST: begin
            if (hit)                                        do_access = 1'b1;
            else if (valid_q[cur_idx] && dirty_q[cur_idx])  state_d   = S_EVICT;
            else                                            state_d   = S_FILL;
         end
         S_EVICT: begin
            MWrite_request = 1'b1;
            MAddress       = {tag_q[cur_idx], cur_idx, {OFFSET_W{1'b0}}};
            MWrite_data    = data_q[cur_idx];
            if (MWrite_done) state_d = S_FILL;
         end
         S_FILL: begin
            MRead_request = 1'b1;
            MAddress      = {cur_tag, cur_idx, {OFFSET_W{1'b0}}};
            if (MRead_ready) begin
               data_d[cur_idx]  = MRead_data;
               tag_d[cur_idx]   = cur_tag;
               valid_d[cur_idx] = 1'b1;
               dirty_d[cur_idx] = 1'b0;
               state_d          = S_ALLOC;
            end
         end
         S_ALLOC: do_access = 1'b1;
         S_R_READY: begin
            PRead_ready = 1'b1;
            if (!PRead_request) state_d = S_IDLE;
         end
         S_W_DONE: begin
            PWrite_done = 1'b1;
            if (!PWrite_request) state_d = S_IDLE;
         end
         S_F_SCAN: begin
            if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
               state_d = S_F_WB;
            end else if (&fidx_q) begin
               fidx_d  = '0;
               state_d = S_F_DONE;
            end else begin
               fidx_d = fidx_q + INDEX_W'(1);
            end
         end
         S_F_WB: begin
            MWrite_request = 1'b1;
            MAddress       = {tag_q[fidx_q], fidx_q, {OFFSET_W{1'b0}}};
            MWrite_data    = data_q[fidx_q];
            if (MWrite_done) begin
               dirty_d[fidx_q] = 1'b0;
               if (&fidx_q) begin
                  fidx_d  = '0;
                  state_d = S_F_DONE;
               end else begin
                  fidx_d  = fidx_q + INDEX_W'(1);
                  state_d = S_F_SCAN;
               end
            end
         end
         S_F_DONE: begin
            Flush_done = 1'b1;
            if (!Flush_request) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // the hit action is shared by TEST (hit) and ALLOC (after a fill)
      if (do_access) begin
         if (is_write_q) begin
            data_d[cur_idx]  = put_word(data_q[cur_idx], cur_off, wdata_q);
            dirty_d[cur_idx] = 1'b1;
            state_d          = S_W_DONE;
         end else begin
            rdata_d = get_word(data_q[cur_idx], cur_off);
            state_d = S_R_READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         rdata_q    <= '0;
         fidx_q     <= '0;
         wr_block_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         rdata_q    <= rdata_d;
         fidx_q     <= fidx_d;
         wr_block_q <= wr_block_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
   end

endmodule

// File: tb/tb_wb_cache.sv
// Bench for wb_cache: directed scenarios plus random traffic, checked against a
// line-level cache model and a flat processor-visible memory image.
module tb_wb_cache;

   localparam int LINES = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        PRead_request = 1'b0, PWrite_request = 1'b0, Flush_request = 1'b0;
   logic [7:0]  PAddress = '0, PWrite_data = '0;
   logic [7:0]  PRead_data;
   logic        PRead_ready, PWrite_done, Flush_done;
   logic        MRead_request, MWrite_request;
   logic [7:0]  MAddress;
   logic [31:0] MWrite_data;
   logic [31:0] MRead_data;
   logic        MRead_ready, MWrite_done;

   always #5 clk = ~clk;

   wb_cache #(.ADDR_W(8), .DATA_W(8), .INDEX_W(3), .OFFSET_W(2)) dut (
      .clk(clk), .rst(rst),
      .PRead_request(PRead_request), .PWrite_request(PWrite_request),
      .PAddress(PAddress), .PWrite_data(PWrite_data),
      .PRead_data(PRead_data), .PRead_ready(PRead_ready), .PWrite_done(PWrite_done),
      .Flush_request(Flush_request), .Flush_done(Flush_done),
      .MRead_request(MRead_request), .MWrite_request(MWrite_request),
      .MAddress(MAddress), .MWrite_data(MWrite_data), .MRead_data(MRead_data),
      .MRead_ready(MRead_ready), .MWrite_done(MWrite_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } mev_t;
   mev_t        exp_q[$];
   logic [7:0]  wb_log[$];
   logic [7:0]  last_fill_addr = '0;
   logic [31:0] last_wb_data = '0;

   logic [7:0]  mem    [256];
   logic [7:0]  golden [256];
   bit          m_valid [LINES];
   bit          m_dirty [LINES];
   logic [2:0]  m_tag   [LINES];
   logic [7:0]  m_line  [LINES][4];
   logic [7:0]  last_rd = '0;
   int          req_cycles = 0;
   bit          mem_stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack_line(input logic [2:0] i);
      return {m_line[i][3], m_line[i][2], m_line[i][1], m_line[i][0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      for (int a = 0; a < 256; a++) golden[a] = mem[a];
      exp_q.delete();
      last_rd = '0;
   endtask

   task automatic model_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               output bit miss);
      logic [2:0] idx, tag;
      logic [7:0] base;
      idx  = a[4:2];
      tag  = a[7:5];
      miss = !(m_valid[idx] && m_tag[idx] == tag);
      if (miss) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            base = {m_tag[idx], idx, 2'b00};
            exp_q.push_back('{1'b1, base, pack_line(idx)});
            for (int w = 0; w < 4; w++) mem[base + 8'(w)] = m_line[idx][w];
         end
         base = {tag, idx, 2'b00};
         for (int w = 0; w < 4; w++) m_line[idx][w] = mem[base + 8'(w)];
         exp_q.push_back('{1'b0, base, pack_line(idx)});
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tag;
      end
      if (wr) begin
         m_line[idx][a[1:0]] = d;
         m_dirty[idx]        = 1'b1;
         golden[a]           = d;
      end
   endtask

   task automatic model_flush(output int nwb);
      logic [7:0] base;
      nwb = 0;
      for (int i = 0; i < LINES; i++) begin
         if (m_valid[i] && m_dirty[i]) begin
            base = {m_tag[i], 3'(i), 2'b00};
            exp_q.push_back('{1'b1, base, pack_line(3'(i))});
            for (int w = 0; w < 4; w++) mem[base + 8'(w)] = m_line[i][w];
            m_dirty[i] = 1'b0;
            nwb++;
         end
      end
   endtask

   always @(negedge clk)
      if (MRead_request || MWrite_request) req_cycles <= req_cycles + 1;

   // memory side: checks every request against the model's expected queue and answers it
   initial begin : mem_side
      mev_t e;
      int   lat;
      int   last_kind;
      bit   aborted;
      MRead_ready = 1'b0;
      MWrite_done = 1'b0;
      MRead_data  = '0;
      last_kind   = 0;
      forever begin
         @(negedge clk);
         if (last_kind == 1)      chk("mrd_drop", 64'(MRead_request), 64'(0));
         else if (last_kind == 2) chk("mwr_drop", 64'(MWrite_request), 64'(0));
         last_kind = 0;
         if (rst) continue;
         if (!(MRead_request || MWrite_request)) begin
            chk("bus_idle", 64'({MAddress, MWrite_data}), 64'(0));
            continue;
         end
         if (exp_q.size() == 0) begin
            chk("unexpected_mreq", 64'({MWrite_request, MRead_request}), 64'(0));
            e = '{MWrite_request, MAddress, 32'h0};
         end else begin
            e = exp_q.pop_front();
            chk("mreq_kind", 64'({MWrite_request, MRead_request}), e.wr ? 64'(2) : 64'(1));
            chk("maddr", 64'(MAddress), 64'(e.addr));
            if (e.wr) chk("mwdata", 64'(MWrite_data), 64'(e.data));
         end
         if (MWrite_request) begin
            wb_log.push_back(MAddress);
            last_wb_data = MWrite_data;
         end else begin
            last_fill_addr = MAddress;
         end
         lat = $urandom_range(0, 3);
         aborted = 1'b0;
         while (mem_stall || lat > 0) begin
            @(negedge clk);
            if (rst) begin
               aborted = 1'b1;
               break;
            end
            if (!mem_stall) lat--;
         end
         if (aborted) continue;
         if (MWrite_request) begin
            MWrite_done = 1'b1;
            last_kind   = 2;
         end else begin
            MRead_data  = e.data;
            MRead_ready = 1'b1;
            last_kind   = 1;
         end
         @(posedge clk);
         #1;
         MRead_ready = 1'b0;
         MWrite_done = 1'b0;
         MRead_data  = '0;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      PRead_request = 1'b0;
      PWrite_request = 1'b0;
      Flush_request = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic do_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                            input bit both, output logic [7:0] rd, output int n);
      bit         miss;
      int         r0;
      logic [7:0] exp_rd, prev_rd;
      exp_rd  = golden[a];
      prev_rd = last_rd;
      model_access(wr, a, d, miss);
      r0 = req_cycles;
      @(posedge clk);
      #1;
      PAddress    = a;
      PWrite_data = d;
      if (wr) PWrite_request = 1'b1;
      else begin
         PRead_request = 1'b1;
         if (both) PWrite_request = 1'b1;
      end
      n = 0;
      forever begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (wr ? PWrite_done : PRead_ready) break;
         if (n >= 400) begin
            chk("access_timeout", 64'({PRead_ready, PWrite_done}), wr ? 64'(1) : 64'(2));
            break;
         end
      end
      chk("access_latency", 64'(n), 64'(2 + (req_cycles - r0) + (miss ? 1 : 0)));
      if (!wr) begin
         chk("read_data", 64'(PRead_data), 64'(exp_rd));
         last_rd = exp_rd;
      end else begin
         chk("read_data_hold", 64'(PRead_data), 64'(prev_rd));
      end
      rd = PRead_data;
      chk("mem_events_done", 64'(exp_q.size()), 64'(0));
      if (wr) PWrite_request = 1'b0;
      else    PRead_request  = 1'b0;
      if (!wr && both) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("blocked_write", 64'(PWrite_done), 64'(0));
         end
         PWrite_request = 1'b0;
      end
      @(negedge clk);
      chk("ready_low", 64'({PRead_ready, PWrite_done}), 64'(0));
   endtask

   task automatic do_flush(output int nwb, output int n);
      int r0;
      model_flush(nwb);
      r0 = req_cycles;
      @(posedge clk);
      #1;
      Flush_request = 1'b1;
      n = 0;
      forever begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (Flush_done) break;
         if (n >= 400) begin
            chk("flush_timeout", 64'(Flush_done), 64'(1));
            break;
         end
      end
      chk("flush_latency", 64'(n), 64'(LINES + 1 + (req_cycles - r0)));
      chk("flush_events_done", 64'(exp_q.size()), 64'(0));
      Flush_request = 1'b0;
      @(negedge clk);
      chk("flush_done_low", 64'(Flush_done), 64'(0));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] rd, a, d;
      int         n, nwb, r;
      bit         miss;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h24] = 8'h11; mem[8'h25] = 8'h22; mem[8'h26] = 8'h33; mem[8'h27] = 8'h44;

      // reset state
      do_reset();
      @(negedge clk);
      chk("rst_ctrl", 64'({PRead_ready, PWrite_done, Flush_done, MRead_request, MWrite_request}), 64'(0));
      chk("rst_rdata", 64'(PRead_data), 64'(0));
      chk("rst_mbus", 64'({MAddress, MWrite_data}), 64'(0));

      // clean miss, then hits
      do_access(1'b0, 8'h24, 8'h00, 1'b0, rd, n);
      chk("t1_rd_24", 64'(rd), 64'(8'h11));
      chk("t1_fill_addr", 64'(last_fill_addr), 64'(8'h24));
      do_access(1'b0, 8'h27, 8'h00, 1'b0, rd, n);
      chk("t1_rd_27", 64'(rd), 64'(8'h44));
      chk("t1_hit_lat", 64'(n), 64'(2));
      do_access(1'b1, 8'h25, 8'hAA, 1'b0, rd, n);
      chk("t2_wr_lat", 64'(n), 64'(2));
      do_access(1'b0, 8'h25, 8'h00, 1'b0, rd, n);
      chk("t2_rd_25", 64'(rd), 64'(8'hAA));

      // dirty eviction
      wb_log.delete();
      do_access(1'b0, 8'hA4, 8'h00, 1'b0, rd, n);
      chk("t3_wb_count", 64'(wb_log.size()), 64'(1));
      chk("t3_wb_addr", 64'(wb_log[0]), 64'(8'h24));
      chk("t3_wb_data", 64'(last_wb_data), 64'(32'h4433AA11));
      chk("t3_fill_addr", 64'(last_fill_addr), 64'(8'hA4));
      do_flush(nwb, n);
      chk("t3_clean_after_fill", 64'(wb_log.size()), 64'(1));
      chk("t3_flush_edges", 64'(n), 64'(9));

      // write-allocate miss
      do_reset();
      wb_log.delete();
      do_access(1'b1, 8'h40, 8'h5A, 1'b0, rd, n);
      chk("t4_fill_addr", 64'(last_fill_addr), 64'(8'h40));
      chk("t4_no_wb", 64'(wb_log.size()), 64'(0));
      do_access(1'b0, 8'h40, 8'h00, 1'b0, rd, n);
      chk("t4_rd_40", 64'(rd), 64'(8'h5A));
      do_flush(nwb, n);
      chk("t4_dirty_wb", 64'(wb_log.size()), 64'(1));
      chk("t4_dirty_wb_addr", 64'(wb_log[0]), 64'(8'h40));

      // flush with dirty lines at index 1 and 3
      do_reset();
      do_access(1'b1, 8'h05, 8'hC1, 1'b0, rd, n);
      do_access(1'b1, 8'h0E, 8'hC3, 1'b0, rd, n);
      wb_log.delete();
      do_flush(nwb, n);
      chk("t5_model_nwb", 64'(nwb), 64'(2));
      chk("t5_wb_count", 64'(wb_log.size()), 64'(2));
      chk("t5_wb_first", 64'(wb_log[0]), 64'(8'h04));
      chk("t5_wb_second", 64'(wb_log[1]), 64'(8'h0C));
      do_flush(nwb, n);
      chk("t5_second_no_wb", 64'(wb_log.size()), 64'(2));
      chk("t5_second_edges", 64'(n), 64'(9));

      // simultaneous read and write: only the read is serviced
      do_access(1'b0, 8'h30, 8'h77, 1'b1, rd, n);
      do_access(1'b1, 8'h30, 8'h77, 1'b0, rd, n);
      do_access(1'b0, 8'h30, 8'h00, 1'b0, rd, n);
      chk("t6_rd_30", 64'(rd), 64'(8'h77));

      // reset during FILL
      do_reset();
      mem_stall = 1'b1;
      model_access(1'b0, 8'h64, 8'h00, miss);
      @(posedge clk);
      #1;
      PAddress = 8'h64;
      PRead_request = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!MRead_request && n < 20);
      chk("t7_fill_started", 64'(MRead_request), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      PRead_request = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t7_mrd_drop_after_rst", 64'(MRead_request), 64'(0));
      model_reset();
      mem_stall = 1'b0;
      do_access(1'b0, 8'h64, 8'h00, 1'b0, rd, n);
      chk("t7_refetch_addr", 64'(last_fill_addr), 64'(8'h64));

      // random traffic
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 99);
         a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         d = 8'($urandom);
         if (r < 40)      do_access(1'b0, a, d, 1'b0, rd, n);
         else if (r < 45) do_access(1'b0, a, d, 1'b1, rd, n);
         else if (r < 90) do_access(1'b1, a, d, 1'b0, rd, n);
         else             do_flush(nwb, n);
      end
      for (int i = 0; i < 8; i++) begin
         a = 8'(i * 4 + 1);
         do_access(1'b0, a, 8'h00, 1'b0, rd, n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
